uart_word_sched: RTL

Arbitrated UART output scheduler for the SoC. It accepts 1–4 byte words from `NUM_REQ` requesters (CPU MMIO port, debug register dump, …) over valid/ready handshakes and grants them round-robin. It sequences the granted word byte-by-byte, most significant byte first, through an internal 8N1 byte serializer driving the single `uart_tx` pin. It replaces ad-hoc per-source transmit state machines at SoC top level.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_byte_tx.sv | 58 +++++
 rtl/uart_word_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and scheduler state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_27M_115200 = 234;
  localparam int UART_FRAME_BITS         = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } sched_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start sampled on an idle cycle, line low from the next cycle, 10 bit-times per frame.
// start is ignored while busy; done pulses on the final stop-bit cycle.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_27M_115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_STOP = 4'(UART_FRAME_BITS - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    data_q;

  assign done = busy && (bit_idx == IDX_STOP) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        tx      <= 1'b0;
        data_q  <= data;
        cnt     <= '0;
        bit_idx <= '0;
      end
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
      if (bit_idx == IDX_STOP) begin
        busy    <= 1'b0;
        tx      <= 1'b1;
        bit_idx <= '0;
      end else begin
        // Next line level: data bit (bit_idx) for indices 1..8, stop bit after that.
        bit_idx <= bit_idx + 4'd1;
        tx      <= (bit_idx < 4'd8) ? data_q[bit_idx[2:0]] : 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_word_sched.sv
// Round-robin scheduler sending 1-4 byte words MSB first on one UART; accept to line-low is 2 cycles.
// req_ready is offered only in IDLE, so requesters hold their word until the running one has fully left the pin.
module uart_word_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_27M_115200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [2*NUM_REQ-1:0]   req_len,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   busy,
  output logic                   uart_tx
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t  state;
  logic [IW-1:0] last;
  logic [IW-1:0] grant;
  logic [31:0]   word;
  logic [1:0]    idx;
  logic          ser_start;
  logic          ser_busy;
  logic          ser_done;
  logic [7:0]    ser_data;

  // Scans last+NUM_REQ down to last+1 so the nearest valid requester after last wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0]      l);
    logic [IW-1:0] pick;
    int            c;
    pick = l;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(l) + k) % NUM_REQ;
      if (v[c]) pick = IW'(c);
    end
    return pick;
  endfunction

  assign grant     = rr_pick(req_valid, last);
  assign ser_start = (state == LOAD);
  assign ser_data  = word[{idx, 3'b000} +: 8];
  assign busy      = !reset && ((state != IDLE) || (|req_valid) || ser_busy);

  always_comb begin
    req_ready = '0;
    if (!reset && (state == IDLE) && (|req_valid)) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= IW'(NUM_REQ - 1);
      word  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            word  <= req_data[{grant, 5'd0} +: 32];
            idx   <= req_len[{grant, 1'b0} +: 2];
            last  <= grant;
            state <= LOAD;
          end
        end
        LOAD: state <= WAIT;
        WAIT: begin
          if (ser_done) begin
            if (idx == 2'd0) begin
              state <= IDLE;
            end else begin
              idx   <= idx - 2'd1;
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .reset(reset),
    .start(ser_start),
    .data (ser_data),
    .busy (ser_busy),
    .done (ser_done),
    .tx   (uart_tx)
  );

endmodule
